// File: rtl/ysyx_24090018_axi_pkg.sv
// Shared AXI4-Lite read-side definitions: response codes, error codes, FSM states, response payload.
package ysyx_24090018_axi_pkg;

  localparam int unsigned AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_BUS      = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_AR    = 3'd1,
    ST_R     = 3'd2,
    ST_RSP   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0]            err;
    logic [AXI_DATA_W-1:0] data;
  } rsp_t;

  // A core load only trusts a plain OKAY; EXOKAY is meaningless for a non-exclusive read.
  function automatic logic resp_is_err(input logic [1:0] resp);
    logic is_err;
    is_err = 1'b1;
    case (resp)
      RESP_OKAY:                             is_err = 1'b0;
      RESP_EXOKAY, RESP_SLVERR, RESP_DECERR: is_err = 1'b1;
      default:                               is_err = 1'b1;
    endcase
    return is_err;
  endfunction

endpackage

// File: rtl/axil_read_master_reg.sv
// Enable register with synchronous active-high clear to zero.
module axil_read_master_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/axil_read_master.sv
// Single-outstanding AXI4-Lite read initiator: core request in, AR/R out, data plus error code back.
module axil_read_master
  import ysyx_24090018_axi_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT);

  state_e        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          drain, drain_d;
  logic          addr_en, rsp_en;
  rsp_t          rsp_d, rsp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      drain <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      drain <= drain_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    drain_d    = drain;
    addr_en    = 1'b0;
    rsp_en     = 1'b0;
    rsp_d.err  = ERR_OK;
    rsp_d.data = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          addr_en = 1'b1;
          if (req_addr[1:0] != 2'b00) begin
            rsp_en    = 1'b1;
            rsp_d.err = ERR_MISALIGN;
            state_d   = ST_RSP;
          end else begin
            state_d = ST_AR;
          end
        end
      end
      ST_AR: begin
        if (arready) begin
          cnt_d   = '0;
          state_d = ST_R;
        end
      end
      ST_R: begin
        if (rvalid) begin
          rsp_en = 1'b1;
          if (resp_is_err(rresp)) begin
            rsp_d.err = ERR_BUS;
          end else begin
            rsp_d.data = rdata;
          end
          state_d = ST_RSP;
        end else begin
          if (cnt != CNT_LIM) cnt_d = cnt + CW'(1);
          // Hitting the limit on a silent cycle abandons the beat; it is swallowed later in DRAIN.
          if (TIMEOUT != 0 && cnt_d == CNT_LIM) begin
            rsp_en    = 1'b1;
            rsp_d.err = ERR_TIMEOUT;
            drain_d   = 1'b1;
            state_d   = ST_RSP;
          end
        end
      end
      ST_RSP: begin
        if (rsp_ready) state_d = drain ? ST_DRAIN : ST_IDLE;
      end
      ST_DRAIN: begin
        if (rvalid) begin
          drain_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  axil_read_master_reg #(.W(ADDR_W)) u_addr_reg (
    .clk (clk),
    .rst (rst),
    .en  (addr_en),
    .d   (req_addr),
    .q   (araddr)
  );

  axil_read_master_reg #(.W($bits(rsp_t))) u_rsp_reg (
    .clk (clk),
    .rst (rst),
    .en  (rsp_en),
    .d   (rsp_d),
    .q   (rsp_q)
  );

  assign rsp_data  = rsp_q.data;
  assign rsp_err   = rsp_q.err;
  assign req_ready = (state == ST_IDLE);
  assign arvalid   = (state == ST_AR);
  assign rready    = (state == ST_R) || (state == ST_DRAIN);
  assign rsp_valid = (state == ST_RSP);

endmodule

// File: tb/tb_axil_read_master.sv
// Directed bench for axil_read_master with a cycle-stepped AXI4-Lite slave model (TIMEOUT = 8).
module tb_axil_read_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  axil_read_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .araddr    (araddr),
    .arvalid   (arvalid),
    .arready   (arready),
    .rdata     (rdata),
    .rresp     (rresp),
    .rvalid    (rvalid),
    .rready    (rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    int          ar_dly;
    int          r_dly;
    int          hold;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    int          exp_hs;
    int          exp_arv;
    int          exp_rsp;
    int          exp_idle;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".arvalid"},   32'(arvalid),   32'd0);
    chk({tag, ".rready"},    32'(rready),    32'd0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rsp_data"},  rsp_data,       32'd0);
    chk({tag, ".rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, ".araddr"},    araddr,         32'd0);
  endtask

  // Cycle 0 = request accepted; the slave model reacts to what the DUT shows each cycle.
  task automatic run_txn(input vec_t v);
    int c, arw, rw, held, hs, arv_cyc, rsp_cyc, idle_cyc;
    bit returned, seen, addr_ok, stable, done;
    logic [31:0] d;
    logic [1:0]  e;
    hs = 0; arv_cyc = -1; rsp_cyc = -1; idle_cyc = -1;
    arw = 0; rw = 0; held = 0;
    returned = 0; seen = 0; addr_ok = 1; stable = 1; done = 0;
    d = '0; e = '0;
    chk({v.name, ".ready_at_start"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = v.addr;
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    for (c = 1; c < 300 && !done; c++) begin
      arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rsp_ready = 1'b0;
      if (seen && !rsp_valid && req_ready) begin
        idle_cyc = c;
        done = 1;
      end else begin
        if (arvalid) begin
          if (arv_cyc < 0) arv_cyc = c;
          if (araddr !== v.addr) addr_ok = 0;
          if (arw >= v.ar_dly) begin
            arready = 1'b1;
            hs++;
          end
          arw++;
        end
        if (rready && hs > 0 && !returned) begin
          if (rw >= v.r_dly) begin
            rvalid = 1'b1;
            rdata  = v.rdata;
            rresp  = v.rresp;
            returned = 1;
          end
          rw++;
        end
        if (rsp_valid) begin
          if (!seen) begin
            seen = 1;
            rsp_cyc = c;
            d = rsp_data;
            e = rsp_err;
          end else if (rsp_data !== d || rsp_err !== e) begin
            stable = 0;
          end
          if (held >= v.hold) rsp_ready = 1'b1;
          held++;
        end
        tick();
      end
    end
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rsp_ready = 1'b0;
    chk({v.name, ".completed"}, 32'(done), 32'd1);
    chk({v.name, ".rsp_data"},  d, v.exp_data);
    chk({v.name, ".rsp_err"},   32'(e), 32'(v.exp_err));
    chk({v.name, ".rsp_cycle"}, 32'(rsp_cyc), 32'(v.exp_rsp));
    chk({v.name, ".idle_cycle"}, 32'(idle_cyc), 32'(v.exp_idle));
    chk({v.name, ".ar_handshakes"}, 32'(hs), 32'(v.exp_hs));
    chk({v.name, ".first_arvalid"}, 32'(arv_cyc), 32'(v.exp_arv));
    chk({v.name, ".araddr_stable"}, 32'(addr_ok), 32'd1);
    chk({v.name, ".rsp_stable"}, 32'(stable), 32'd1);
  endtask

  vec_t vecs[8];
  vec_t post_rst;

  initial begin
    //        name          addr          rdata         rr  ard rd hold exp_data      err  hs arv rsp idle
    vecs[0] = '{"aligned",   32'h80000004, 32'hDEADBEEF, 2'b00, 0, 0, 0, 32'hDEADBEEF, 2'b00, 1,  1,  3,  4};
    vecs[1] = '{"wait",      32'h80000010, 32'hCAFEF00D, 2'b00, 5, 3, 2, 32'hCAFEF00D, 2'b00, 1,  1, 11, 14};
    vecs[2] = '{"slverr",    32'h80000008, 32'h12345678, 2'b10, 0, 0, 1, 32'h00000000, 2'b01, 1,  1,  3,  5};
    vecs[3] = '{"misalign2", 32'h80000002, 32'h11111111, 2'b00, 0, 0, 0, 32'h00000000, 2'b10, 0, -1,  1,  2};
    vecs[4] = '{"edge_data", 32'h10000000, 32'h0BADF00D, 2'b00, 0, 7, 0, 32'h0BADF00D, 2'b00, 1,  1, 10, 11};
    vecs[5] = '{"exokay",    32'h2000000C, 32'h55AA55AA, 2'b01, 1, 1, 0, 32'h00000000, 2'b01, 1,  1,  5,  6};
    vecs[6] = '{"timeout",   32'h80000020, 32'h77777777, 2'b00, 0, 20, 0, 32'h00000000, 2'b11, 1, 1, 10, 24};
    vecs[7] = '{"after_to",  32'h80000024, 32'hA5A5A5A5, 2'b00, 0, 0, 0, 32'hA5A5A5A5, 2'b00, 1,  1,  3,  4};
    post_rst = '{"post_rst", 32'h80000044, 32'h0F0F0F0F, 2'b00, 2, 1, 0, 32'h0F0F0F0F, 2'b00, 1,  1,  6,  7};

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk_reset_outputs("init");

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset while waiting in R with the core not ready: the transaction is abandoned.
    req_valid = 1'b1;
    req_addr  = 32'h80000040;
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    chk("rst_seq.arvalid", 32'(arvalid), 32'd1);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    tick();
    chk("rst_seq.rready", 32'(rready), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("mid_r_reset");
    run_txn(post_rst);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
